// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// Ownership is held for a whole packet (until a byte flagged last) or until the lock times out.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ-1:0]            req_last_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          tx_start_out,
  output logic [DATA_WIDTH-1:0]         tx_data_out,
  input  logic                          tx_busy_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic                          lock_drop_out
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CND_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        owner;
  logic [TMR_W-1:0]        timer;
  logic                    last_q;

  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic [CND_W-1:0]        cand;
  logic [DATA_WIDTH-1:0]   own_data;
  logic                    own_valid;
  logic                    own_last;
  logic [PTR_W-1:0]        nxt_ptr;

  // First valid requester scanning upward from rr_ptr; wrap is an explicit compare.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CND_W'(k);
      if (cand >= CND_W'(NUM_REQ)) cand = cand - CND_W'(NUM_REQ);
      if (!win_found && req_valid_in[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Owner's byte lane, selected by the one-hot grant.
  always_comb begin
    own_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_out[i]) own_data = own_data | req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign own_valid     = |(req_valid_in & grant_out);
  assign own_last      = |(req_last_in & grant_out);
  assign nxt_ptr       = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign req_ready_out = (state == S_ACCEPT) ? grant_out : '0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      timer         <= '0;
      last_q        <= 1'b0;
      tx_start_out  <= 1'b0;
      tx_data_out   <= '0;
      grant_out     <= '0;
      lock_drop_out <= 1'b0;
    end else begin
      tx_start_out  <= 1'b0;
      lock_drop_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_out <= NUM_REQ'(1) << win_idx;
            owner     <= win_idx;
            timer     <= '0;
            state     <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          // An accept in the same cycle the timer expires takes priority over the revoke.
          if (own_valid) begin
            tx_data_out  <= own_data;
            last_q       <= own_last;
            tx_start_out <= 1'b1;
            state        <= S_WAIT_BUSY;
          end else if (timer == TMR_MAX) begin
            grant_out     <= '0;
            rr_ptr        <= nxt_ptr;
            lock_drop_out <= 1'b1;
            state         <= S_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy_in) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy_in) begin
            if (last_q) begin
              rr_ptr    <= nxt_ptr;
              grant_out <= '0;
              state     <= S_IDLE;
            end else begin
              timer <= '0;
              state <= S_ACCEPT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte sources and a 10-cycle busy transmitter
// are modelled inside the step task so all inputs change 1ns after the rising edge.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LT = 16;
  localparam int BUSY_CYC = 10;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [NR-1:0]   req_valid_in = '0;
  logic [NR-1:0]   req_last_in = '0;
  logic [NR*DW-1:0] req_data_in = '0;
  logic [NR-1:0]   req_ready_out;
  logic            tx_start_out;
  logic [DW-1:0]   tx_data_out;
  logic            tx_busy_in = 1'b0;
  logic [NR-1:0]   grant_out;
  logic            lock_drop_out;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_last_in(req_last_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .tx_start_out(tx_start_out), .tx_data_out(tx_data_out),
    .tx_busy_in(tx_busy_in), .grant_out(grant_out), .lock_drop_out(lock_drop_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [8:0] src_mem [0:3][0:31];
  int src_head [4];
  int src_tail [4];
  logic [7:0] log_data [$];
  logic [3:0] log_grant [$];
  int log_cyc [$];
  logic drop_seen = 1'b0;
  logic [3:0] grant_seen = '0;
  logic ready0_in_lock = 1'b0;

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req_valid_in[i]       = 1'b1;
        req_last_in[i]        = src_mem[i][src_head[i]][8];
        req_data_in[i*8 +: 8] = src_mem[i][src_head[i]][7:0];
      end else begin
        req_valid_in[i]       = 1'b0;
        req_last_in[i]        = 1'b0;
        req_data_in[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    src_mem[r][src_tail[r]] = {last, d};
    src_tail[r]++;
    drive_src();
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    drive_src();
  endtask

  task automatic clear_log();
    log_data.delete();
    log_grant.delete();
    log_cyc.delete();
  endtask

  // One clock: pops accepted bytes, advances the transmitter model, records observations.
  task automatic step();
    logic [3:0] acc;
    logic st;
    acc = req_valid_in & req_ready_out;
    st  = tx_start_out;
    @(posedge clk_in);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (acc[i]) src_head[i]++;
    if (st) busy_cnt = BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy_in = (busy_cnt != 0);
    drive_src();
    if (tx_start_out) begin
      log_data.push_back(tx_data_out);
      log_grant.push_back(grant_out);
      log_cyc.push_back(cyc);
    end
    if (lock_drop_out) drop_seen = 1'b1;
    grant_seen = grant_seen | grant_out;
    if (grant_out == 4'b0010 && req_ready_out[0]) ready0_in_lock = 1'b1;
  endtask

  function automatic logic srcs_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < 4; i++) if (src_head[i] < src_tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic run_idle(input int max, input string name);
    int n;
    n = 0;
    while (!(srcs_empty() && grant_out == '0 && !tx_busy_in && !tx_start_out) && n < max) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= max) begin
      n_fail++;
      $display("FAIL %s_idle: still busy after %0d cycles, required return to idle", name, n);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    clear_src();
    busy_cnt = 0;
    tx_busy_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req_ready_out !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready_out); end
    n_checks++; if (tx_start_out !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", tx_start_out); end
    n_checks++; if (tx_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx_data_out); end
    n_checks++; if (grant_out !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant_out); end
    n_checks++; if (lock_drop_out !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", lock_drop_out); end
    n_checks++; if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr: got %0d want 0", dut.rr_ptr); end
  endtask

  task automatic test_single_packet();
    clear_log();
    grant_seen = '0;
    push(2, 1'b0, 8'h48);
    push(2, 1'b1, 8'h49);
    step();
    n_checks++; if (grant_out !== 4'b0100) begin n_fail++; $display("FAIL sp_grant_latency: got %b want 0100", grant_out); end
    n_checks++; if (req_ready_out !== 4'b0100) begin n_fail++; $display("FAIL sp_ready_latency: got %b want 0100", req_ready_out); end
    step();
    n_checks++; if (tx_start_out !== 1'b1 || tx_data_out !== 8'h48) begin n_fail++; $display("FAIL sp_first_start: got start=%b data=%h want 1/48", tx_start_out, tx_data_out); end
    run_idle(200, "sp");
    n_checks++; if (log_data.size() != 2) begin n_fail++; $display("FAIL sp_count: got %0d starts want 2", log_data.size()); end
    n_checks++; if (log_data[0] !== 8'h48 || log_data[1] !== 8'h49) begin n_fail++; $display("FAIL sp_data: got %h %h want 48 49", log_data[0], log_data[1]); end
    n_checks++; if (log_grant[0] !== 4'b0100 || log_grant[1] !== 4'b0100) begin n_fail++; $display("FAIL sp_start_grant: got %b %b want 0100", log_grant[0], log_grant[1]); end
    n_checks++; if (grant_seen !== 4'b0100) begin n_fail++; $display("FAIL sp_grant_only2: got %b want 0100", grant_seen); end
    // Same-packet byte spacing: 1 (start->busy) + 10 busy + 2 arbiter overhead.
    n_checks++; if (log_cyc[1] - log_cyc[0] != 13) begin n_fail++; $display("FAIL sp_spacing: got %0d want 13", log_cyc[1] - log_cyc[0]); end
    n_checks++; if (dut.rr_ptr !== 2'd3) begin n_fail++; $display("FAIL sp_rr: got %0d want 3", dut.rr_ptr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    clear_log();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++) push(r, 1'b1, 8'(8'h10 + r));
    run_idle(600, "rr");
    n_checks++; if (log_grant.size() != 8) begin n_fail++; $display("FAIL rr_count: got %0d starts want 8", log_grant.size()); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (log_grant[k] !== exp_g[k]) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", k, log_grant[k], exp_g[k]); end
    end
    n_checks++; if (log_data[4] !== 8'h10) begin n_fail++; $display("FAIL rr_data4: got %h want 10", log_data[4]); end
  endtask

  task automatic test_packet_lock();
    clear_log();
    ready0_in_lock = 1'b0;
    push(1, 1'b0, 8'hA1);
    push(1, 1'b0, 8'hA2);
    push(1, 1'b1, 8'hA3);
    step();
    push(0, 1'b1, 8'hB0);
    run_idle(300, "lock");
    n_checks++; if (log_data.size() != 4) begin n_fail++; $display("FAIL lock_count: got %0d starts want 4", log_data.size()); end
    n_checks++;
    if (log_data[0] !== 8'hA1 || log_data[1] !== 8'hA2 || log_data[2] !== 8'hA3 || log_data[3] !== 8'hB0) begin
      n_fail++; $display("FAIL lock_data: got %h %h %h %h want a1 a2 a3 b0", log_data[0], log_data[1], log_data[2], log_data[3]);
    end
    n_checks++;
    if (log_grant[0] !== 4'b0010 || log_grant[1] !== 4'b0010 || log_grant[2] !== 4'b0010 || log_grant[3] !== 4'b0001) begin
      n_fail++; $display("FAIL lock_grant: got %b %b %b %b want 0010 x3 then 0001", log_grant[0], log_grant[1], log_grant[2], log_grant[3]);
    end
    n_checks++; if (log_cyc[2] - log_cyc[0] != 26) begin n_fail++; $display("FAIL lock_back2back: got %0d want 26", log_cyc[2] - log_cyc[0]); end
    // New packet goes through S_IDLE: one extra cycle over the same-packet spacing.
    n_checks++; if (log_cyc[3] - log_cyc[2] != 14) begin n_fail++; $display("FAIL lock_handover: got %0d want 14", log_cyc[3] - log_cyc[2]); end
    n_checks++; if (ready0_in_lock !== 1'b0) begin n_fail++; $display("FAIL lock_ready0: got %b want 0", ready0_in_lock); end
  endtask

  // Run until owner 3's first byte has started and ownership re-enters accept.
  task automatic wait_reentry(input string name);
    int n;
    n = 0;
    while (log_data.size() == 0 && n < 30) begin step(); n++; end
    while (req_ready_out !== 4'b1000 && n < 60) begin step(); n++; end
    n_checks++;
    if (n >= 60) begin n_fail++; $display("FAIL %s_reentry: no re-entry after %0d cycles", name, n); end
  endtask

  task automatic test_lock_timeout();
    clear_log();
    drop_seen = 1'b0;
    push(3, 1'b0, 8'hC3);
    wait_reentry("to");
    repeat (16) step();
    n_checks++; if (drop_seen !== 1'b0 || grant_out !== 4'b1000) begin n_fail++; $display("FAIL to_early: got drop=%b grant=%b want 0/1000", drop_seen, grant_out); end
    step();
    n_checks++; if (lock_drop_out !== 1'b1) begin n_fail++; $display("FAIL to_drop: got %b want 1", lock_drop_out); end
    n_checks++; if (grant_out !== 4'b0000) begin n_fail++; $display("FAIL to_grant: got %b want 0000", grant_out); end
    n_checks++; if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL to_rr: got %0d want 0", dut.rr_ptr); end
    step();
    n_checks++; if (lock_drop_out !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", lock_drop_out); end
  endtask

  task automatic test_timeout_race();
    clear_log();
    push(3, 1'b0, 8'hD0);
    wait_reentry("race");
    drop_seen = 1'b0;
    repeat (16) step();
    push(3, 1'b1, 8'hD1);
    step();
    n_checks++; if (tx_start_out !== 1'b1 || tx_data_out !== 8'hD1) begin n_fail++; $display("FAIL race_accept: got start=%b data=%h want 1/d1", tx_start_out, tx_data_out); end
    n_checks++; if (lock_drop_out !== 1'b0) begin n_fail++; $display("FAIL race_drop: got %b want 0", lock_drop_out); end
    run_idle(100, "race");
    n_checks++; if (drop_seen !== 1'b0) begin n_fail++; $display("FAIL race_no_drop: got %b want 0", drop_seen); end
    n_checks++; if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL race_rr: got %0d want 0", dut.rr_ptr); end
  endtask

  task automatic test_reset_mid_byte();
    int n;
    clear_log();
    push(2, 1'b1, 8'hE2);
    run_idle(100, "rst_pre");
    push(3, 1'b1, 8'hE3);
    n = 0;
    while (!tx_busy_in && n < 30) begin step(); n++; end
    step();
    step();
    n_checks++; if (grant_out !== 4'b1000 || !tx_busy_in) begin n_fail++; $display("FAIL rst_setup: got grant=%b busy=%b want 1000/1", grant_out, tx_busy_in); end
    push(1, 1'b1, 8'hE1);
    #2;
    rst_in = 1'b1;
    #1;
    n_checks++; if (req_ready_out !== 4'b0 || grant_out !== 4'b0) begin n_fail++; $display("FAIL rst_async_grant: got ready=%b grant=%b want 0000", req_ready_out, grant_out); end
    n_checks++; if (tx_data_out !== 8'h00 || tx_start_out !== 1'b0 || lock_drop_out !== 1'b0) begin n_fail++; $display("FAIL rst_async_out: got data=%h start=%b drop=%b want 0", tx_data_out, tx_start_out, lock_drop_out); end
    busy_cnt = 0;
    tx_busy_in = 1'b0;
    push(3, 1'b1, 8'hF3);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    n_checks++; if (grant_out !== 4'b0010) begin n_fail++; $display("FAIL rst_first_grant: got %b want 0010", grant_out); end
    run_idle(200, "rst_post");
  endtask

  initial begin
    clear_src();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_packet_lock();
    test_lock_timeout();
    test_timeout_race();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART serial transmitter among `NUM_REQ` byte-stream requesters using round-robin arbitration with packet lock. A grant is held until the owner sends a byte flagged `last`, so packets are never interleaved on the line. The block sits between client logic (debug printers, status reporters, echo path from the serial receiver) and the transmitter's `start`/`busy` handshake, and sequences one byte at a time into it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be at least 2; need not be a power of two.
- `DATA_WIDTH`, 8: byte width.
- `LOCK_TIMEOUT`, 4096: cycles a locked owner may sit idle mid-packet before its lock is revoked.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `req_valid_in`  in  NUM_REQ  per-requester byte valid.
- `req_last_in`  in  NUM_REQ  per-requester last-byte-of-packet flag; qualified by valid.
- `req_data_in`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready_out`  out  NUM_REQ  one-hot or zero; byte i is accepted on a clock edge where `req_valid_in[i] & req_ready_out[i]`.
- `tx_start_out`  out  1  one-cycle start pulse to the transmitter.
- `tx_data_out`  out  DATA_WIDTH  byte to the transmitter; stable from the start pulse until the next accept.
- `tx_busy_in`  in  1  transmitter busy, covering the start, data and stop bits.
- `grant_out`  out  NUM_REQ  one-hot current owner; zero when no owner.
- `lock_drop_out`  out  1  one-cycle pulse when a lock is revoked by timeout.

## Operation
- The state machine has four states: S_IDLE, S_ACCEPT, S_WAIT_BUSY, S_WAIT_DONE. All outputs are registered except `req_ready_out`, which equals `grant_out` while in S_ACCEPT and is zero otherwise.
- **S_IDLE:** `grant_out` is 0. If any `req_valid_in` bit is set, pick the winner: the first valid index in the order `rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …`. Load the winner into `grant_out`, clear the timer, and go to S_ACCEPT.
- **S_ACCEPT:**
  - If the owner's valid is high, the byte is accepted. Latch its data into `tx_data_out` and its last flag into `last_q`, set `tx_start_out` to 1, and go to S_WAIT_BUSY.
  - Otherwise increment the timer.
  - When the timer equals `LOCK_TIMEOUT`: clear `grant_out`, advance `rr_ptr`, pulse `lock_drop_out`, and go to S_IDLE.
  - If valid is high in the same cycle the timer reaches `LOCK_TIMEOUT`, the accept wins.
- **S_WAIT_BUSY:** `tx_start_out` returns to 0 after exactly one cycle. Wait for `tx_busy_in` = 1, then go to S_WAIT_DONE. There is no timeout in this state.
- **S_WAIT_DONE:** wait for `tx_busy_in` = 0.
  - If `last_q` = 1: set `rr_ptr` to (owner+1), wrapping to 0 when owner+1 = NUM_REQ. Clear `grant_out` and go to S_IDLE.
  - Otherwise go back to S_ACCEPT with the timer cleared.
- Valid requests from non-owners are ignored while a lock is held. They must hold their valid until they are served.
- Width rules:
  - `rr_ptr` is `$clog2(NUM_REQ)` bits and wraps by explicit compare, never by overflow.
  - The timer is `$clog2(LOCK_TIMEOUT+1)` bits and saturates at `LOCK_TIMEOUT`.
- **Reset:** `rst_in` asynchronously forces S_IDLE, `rr_ptr` = 0, and the timer to 0. Every output goes to 0: `req_ready_out`, `tx_start_out`, `tx_data_out`, `grant_out`, `lock_drop_out`. Reset mid-byte drops ownership immediately. The transmitter is reset by the same `rst_in`.

## Timing
- Arbitration latency: a valid request sampled in S_IDLE at edge N gives `grant_out` and `req_ready_out` high after edge N; the byte is accepted at edge N+1.
- The accept edge and the rising edge of `tx_start_out` are the same edge.
- A busy signal that rises at the earliest possible time (the cycle after the start pulse) is handled with no lost start.
- The next byte of the same packet can be accepted 1 cycle after `tx_busy_in` falls (S_WAIT_DONE → S_ACCEPT). Arbiter overhead is therefore 2 cycles per byte beyond the transmitter's busy time.
- A new packet starts 2 cycles after `tx_busy_in` falls (S_WAIT_DONE → S_IDLE → S_ACCEPT).
- `lock_drop_out` is high for exactly the one cycle following the revoking edge.

## Test plan
- **Single packet:** requester 2 sends bytes 0x48 and 0x49 with `last` on 0x49; the transmitter model holds busy for 10 cycles. Required: two `tx_start_out` pulses carrying 0x48 then 0x49, `grant_out` = 4'b0100 throughout, and `rr_ptr` = 3 afterwards.
- **Round-robin fairness:** all four requesters hold continuous single-byte packets after reset. Required: grant order 0, 1, 2, 3, 0, and no requester is served twice before all others are served once.
- **Packet lock:** requester 1 sends a 3-byte packet while requester 0 is valid throughout. Required: all three of requester 1's bytes go out back to back, then requester 0 is granted; requester 0's ready stays 0 during the lock.
- **Lock timeout:** use `LOCK_TIMEOUT` = 16. Requester 3 sends a non-last byte and then drops valid. Required: `lock_drop_out` pulses 16 cycles after re-entry to S_ACCEPT, `grant_out` = 0, and `rr_ptr` = 0 (wrapped from owner 3).
- **Timeout race:** requester 3's valid rises in the same cycle the timer hits `LOCK_TIMEOUT`. Required: the byte is accepted, `tx_start_out` pulses, and there is no `lock_drop_out`.
- **Reset mid-byte:** assert `rst_in` asynchronously during S_WAIT_DONE. Required: all outputs are 0 before the next clock edge; after release, the first grant goes to the lowest valid index starting from 0.
